// File: rtl/alu_sequencer.sv
// alu_sequencer: issue controller for the combinational ALU.
// Accepts one RV32 OP / OP-IMM instruction at a time and decodes it into alufun/op2sel.
// It holds the ALU inputs for ALU_LAT cycles, captures the result, and offers it on a
// valid/ready writeback port.
// Optional feature: define ALU_SEQ_BYPASS_EN to let a new instruction be accepted in the
// same cycle as a writeback transfer.
module alu_sequencer #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic [2:0]      alu_fun,
    output logic [1:0]      alu_op2sel,
    output logic [31:0]     alu_inst,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_op2,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result,
    output logic            out_err
);

    localparam int unsigned CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;

    logic            dec_legal;
    logic [2:0]      dec_fun;
    logic [1:0]      dec_op2sel;
    logic [XLEN-1:0] dec_op2;
    logic [XLEN-1:0] raw_op2;
    logic            accept;

    // Decode the offered instruction into ALU controls and operand 2
    always_comb begin
        dec_legal  = 1'b0;
        dec_fun    = in_inst[14:12];
        dec_op2sel = 2'd1;
        raw_op2    = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
        if (in_inst[6:0] == 7'b0110011) begin
            dec_op2sel = 2'd3;
            raw_op2    = in_rs2_val;
        end
        dec_op2 = raw_op2;
        if (in_inst[14:12] == 3'b001) begin
            dec_op2 = {{(XLEN-5){1'b0}}, raw_op2[4:0]};
        end
        case (in_inst[6:0])
            7'b0010011: dec_legal = (in_inst[14:12] == 3'b000) || (in_inst[14:12] == 3'b110) ||
                                    ((in_inst[14:12] == 3'b001) && (in_inst[31:25] == 7'd0));
            7'b0110011: dec_legal = (in_inst[31:25] == 7'd0) &&
                                    ((in_inst[14:12] == 3'b000) || (in_inst[14:12] == 3'b001) ||
                                     (in_inst[14:12] == 3'b110));
            default:    dec_legal = 1'b0;
        endcase
    end

    // Accept readiness: IDLE always, WB only alongside a writeback transfer when bypassing
    always_comb begin
`ifdef ALU_SEQ_BYPASS_EN
        in_ready = (state == IDLE) || ((state == WB) && out_ready);
`else
        in_ready = (state == IDLE);
`endif
    end

    assign accept = in_valid && in_ready;

    // Sequencer FSM with registered ALU-side and writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            alu_fun    <= '0;
            alu_op2sel <= '0;
            alu_inst   <= '0;
            alu_rs1    <= '0;
            alu_op2    <= '0;
            out_valid  <= 1'b0;
            out_rd     <= '0;
            out_result <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    if (count == CW'(1)) begin
                        out_result <= alu_result;
                        out_err    <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= WB;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                WB: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
            // An accept (IDLE, or WB with bypass) overrides the WB->IDLE move above
            if (accept) begin
                out_rd <= in_inst[11:7];
                if (dec_legal) begin
                    state      <= EXEC;
                    count      <= CW'(ALU_LAT);
                    alu_fun    <= dec_fun;
                    alu_op2sel <= dec_op2sel;
                    alu_inst   <= in_inst;
                    alu_rs1    <= in_rs1_val;
                    alu_op2    <= dec_op2;
                    out_valid  <= 1'b0;
                end else begin
                    state      <= WB;
                    out_valid  <= 1'b1;
                    out_err    <= 1'b1;
                    out_result <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer (XLEN=32, ALU_LAT=1) with a stand-in ALU.
// Build with ALU_SEQ_BYPASS_EN defined to exercise the bypass throughput.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [2:0]  alu_fun;
    logic [1:0]  alu_op2sel;
    logic [31:0] alu_inst;
    logic [31:0] alu_rs1;
    logic [31:0] alu_op2;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

`ifdef ALU_SEQ_BYPASS_EN
    localparam int EXP_GAP = 2;
`else
    localparam int EXP_GAP = 3;
`endif

    alu_sequencer #(.XLEN(32), .ALU_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .alu_fun    (alu_fun),
        .alu_op2sel (alu_op2sel),
        .alu_inst   (alu_inst),
        .alu_rs1    (alu_rs1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_result (out_result),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    // Stand-in combinational ALU
    always_comb begin
        case (alu_fun)
            3'b000:  alu_result = alu_rs1 + alu_op2;
            3'b001:  alu_result = alu_rs1 << alu_op2[4:0];
            3'b110:  alu_result = alu_rs1 | alu_op2;
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    int wb_cyc[$];
    logic [31:0] wb_val[$];
    logic acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0;
        in_rs1_val = '0; in_rs2_val = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_result", out_result, 0);
        check("rst_alu_fun", alu_fun, 0);
        check("rst_alu_op2", alu_op2, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // ADDI x5,x1,-3 with rs1=10
        in_valid = 1'b1; in_inst = 32'hFFD08293; in_rs1_val = 32'd10; in_rs2_val = 32'hDEAD;
        check("addi_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("addi_fun", alu_fun, 3'b000);
        check("addi_op2sel", alu_op2sel, 2'd1);
        check("addi_op2", alu_op2, 32'hFFFFFFFD);
        check("addi_rs1", alu_rs1, 32'd10);
        check("addi_inst", alu_inst, 32'hFFD08293);
        check("addi_valid_early", out_valid, 0);
        tick();
        check("addi_valid", out_valid, 1);
        check("addi_rd", out_rd, 5);
        check("addi_result", out_result, 7);
        check("addi_err", out_err, 0);
        // Writeback back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_result", out_result, 7);
            check("hold_rd", out_rd, 5);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);

        // SLL x3,x1,x2 with rs1=1, rs2=0x24
        in_valid = 1'b1; in_inst = 32'h002091B3; in_rs1_val = 32'd1; in_rs2_val = 32'h24;
        tick();
        in_valid = 1'b0;
        check("sll_fun", alu_fun, 3'b001);
        check("sll_op2sel", alu_op2sel, 2'd3);
        check("sll_op2", alu_op2, 32'd4);
        tick();
        check("sll_valid", out_valid, 1);
        check("sll_result", out_result, 32'h10);
        check("sll_rd", out_rd, 3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // SUB is illegal: straight to WB, ALU side untouched
        in_valid = 1'b1; in_inst = 32'h402081B3; in_rs1_val = 32'd9; in_rs2_val = 32'd9;
        tick();
        in_valid = 1'b0;
        check("sub_valid", out_valid, 1);
        check("sub_err", out_err, 1);
        check("sub_result", out_result, 0);
        check("sub_alu_fun", alu_fun, 3'b001);
        check("sub_alu_op2", alu_op2, 32'd4);
        check("sub_alu_inst", alu_inst, 32'h002091B3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // SLLI with nonzero inst[31:25] is illegal
        in_valid = 1'b1; in_inst = 32'h40309213; in_rs1_val = 32'd5;
        tick();
        in_valid = 1'b0;
        check("slli_bad_err", out_err, 1);
        check("slli_bad_rd", out_rd, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // SLLI x4,x1,3 with rs1=5 (legal, clears prior error)
        in_valid = 1'b1; in_inst = 32'h00309213; in_rs1_val = 32'd5;
        tick();
        in_valid = 1'b0;
        check("slli_op2", alu_op2, 32'd3);
        tick();
        check("slli_result", out_result, 32'h28);
        check("slli_err", out_err, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // LUI opcode is unsupported
        in_valid = 1'b1; in_inst = 32'h000012B7;
        tick();
        in_valid = 1'b0;
        check("lui_err", out_err, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of EXEC
        in_valid = 1'b1; in_inst = 32'hFFD08293; in_rs1_val = 32'd10;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_op2", alu_op2, 0);
        check("midrst_rs1", alu_rs1, 0);
        check("midrst_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();

        // ORI x7,x2,0xF0 after reset
        in_valid = 1'b1; in_inst = 32'h0F016393; in_rs1_val = 32'h00000F0F;
        tick();
        in_valid = 1'b0;
        check("ori_fun", alu_fun, 3'b110);
        check("ori_op2", alu_op2, 32'hF0);
        tick();
        check("ori_valid", out_valid, 1);
        check("ori_result", out_result, 32'hFFF);
        check("ori_rd", out_rd, 7);
        out_ready = 1'b1;
        tick();

        // Back-to-back ADDIs with out_ready held high
        in_valid = 1'b1; in_inst = 32'hFFD08293; in_rs1_val = 32'd100;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                wb_cyc.push_back(c);
                wb_val.push_back(out_result);
            end
            acc = in_ready;
            tick();
            if (acc) in_rs1_val = in_rs1_val + 32'd1;
        end
        in_valid = 1'b0;
        check("tput_count", wb_cyc.size() >= 3, 1);
        if (wb_cyc.size() >= 3) begin
            check("tput_gap0", wb_cyc[1] - wb_cyc[0], EXP_GAP);
            check("tput_gap1", wb_cyc[2] - wb_cyc[1], EXP_GAP);
            check("tput_first_cycle", wb_cyc[0], 2);
            check("tput_val0", wb_val[0], 97);
            check("tput_val1", wb_val[1], 98);
            check("tput_val2", wb_val[2], 99);
        end
        for (int i = 0; i < 4; i++) tick();
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
